// File: rtl/grid_draw_ctrl.sv
// Sequencer for the Game-of-Life cell/mouse drawing datapath: walks the board, drives load/plot strobes.
// Optional continuous refresh: define GRID_AUTO_FRAME_EN to restart each frame straight after DONE.
module grid_draw_ctrl #(
  parameter int ROWS      = 30,
  parameter int COLS      = 40,
  parameter int CELL_PIX  = 16,
  parameter int MOUSE_PIX = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       mouse_req,
  output logic [4:0] register,
  output logic       mem_rd,
  output logic [5:0] addr,
  output logic       ld_x,
  output logic       ld_y,
  output logic       ld_c,
  output logic       enable,
  output logic       plot,
  output logic       mouse_plot,
  output logic       reset_score,
  output logic       busy,
  output logic       done
);

  localparam int PW = $clog2(CELL_PIX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_LOAD, S_DRAW, S_M_LOAD, S_M_DRAW, S_DONE
  } state_t;

  state_t        r_state, r_ret;
  logic [4:0]    r_row;
  logic [5:0]    r_col;
  logic [PW-1:0] r_pix;
  logic          r_mouse_pend;
  logic          r_mem_rd, r_ld_xy, r_ld_c, r_enable, r_mouse_plot;
  logic          r_reset_score, r_busy, r_done;

  state_t        w_state_next, w_ret_next, w_target;
  logic [4:0]    w_row_next;
  logic [5:0]    w_col_next;
  logic [PW-1:0] w_pix_next;
  logic          w_pend;

  // A request seen this very cycle counts as pending, so an idle redraw starts without delay.
  assign w_pend = r_mouse_pend | mouse_req;

  always_comb begin
    w_state_next = r_state;
    w_ret_next   = r_ret;
    w_row_next   = r_row;
    w_col_next   = r_col;
    w_pix_next   = r_pix;
    w_target     = S_DONE;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_CLEAR;
        end else if (w_pend) begin
          w_state_next = S_M_LOAD;
          w_ret_next   = S_IDLE;
        end
      end
      S_CLEAR: w_state_next = S_FETCH;
      S_FETCH: w_state_next = S_LOAD;
      S_LOAD: begin
        w_state_next = S_DRAW;
        w_pix_next   = '0;
      end
      S_DRAW: begin
        w_pix_next = r_pix + 1'b1;
        if (r_pix == PW'(CELL_PIX - 1)) begin
          if (r_col < 6'(COLS - 1)) begin
            w_col_next = r_col + 1'b1;
            w_target   = S_LOAD;
          end else if (r_row < 5'(ROWS - 1)) begin
            w_row_next = r_row + 1'b1;
            w_col_next = '0;
            w_target   = S_FETCH;
          end
          // The cursor draw disturbs the row word, so any in-frame return goes through FETCH.
          if (w_pend) begin
            w_state_next = S_M_LOAD;
            w_ret_next   = (w_target == S_DONE) ? S_DONE : S_FETCH;
          end else begin
            w_state_next = w_target;
          end
        end
      end
      S_M_LOAD: begin
        w_state_next = S_M_DRAW;
        w_pix_next   = '0;
      end
      S_M_DRAW: begin
        w_pix_next = r_pix + 1'b1;
        if (r_pix == PW'(MOUSE_PIX - 1)) w_state_next = r_ret;
      end
      S_DONE: begin
`ifdef GRID_AUTO_FRAME_EN
        w_state_next = S_CLEAR;
`else
        w_state_next = S_IDLE;
`endif
      end
      default: w_state_next = S_IDLE;
    endcase
    if (w_state_next == S_CLEAR) begin
      w_row_next = '0;
      w_col_next = '0;
    end
  end

  // Strobes are decoded from the next state so every output is a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_ret         <= S_IDLE;
      r_row         <= '0;
      r_col         <= '0;
      r_pix         <= '0;
      r_mouse_pend  <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_ld_xy       <= 1'b0;
      r_ld_c        <= 1'b0;
      r_enable      <= 1'b0;
      r_mouse_plot  <= 1'b0;
      r_reset_score <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_ret         <= w_ret_next;
      r_row         <= w_row_next;
      r_col         <= w_col_next;
      r_pix         <= w_pix_next;
      r_mouse_pend  <= (r_state == S_M_LOAD) ? mouse_req : (r_mouse_pend | mouse_req);
      r_mem_rd      <= (w_state_next == S_FETCH);
      r_ld_xy       <= (w_state_next == S_LOAD) || (w_state_next == S_M_LOAD);
      r_ld_c        <= (w_state_next == S_LOAD);
      r_enable      <= (w_state_next == S_DRAW) || (w_state_next == S_M_DRAW);
      r_mouse_plot  <= (w_state_next == S_M_LOAD) || (w_state_next == S_M_DRAW);
      r_reset_score <= (w_state_next != S_CLEAR);
      r_done        <= (w_state_next == S_DONE);
      if (w_state_next == S_CLEAR)     r_busy <= 1'b1;
      else if (w_state_next == S_DONE) r_busy <= 1'b0;
    end
  end

  assign register    = r_row;
  assign addr        = r_col;
  assign mem_rd      = r_mem_rd;
  assign ld_x        = r_ld_xy;
  assign ld_y        = r_ld_xy;
  assign ld_c        = r_ld_c;
  assign enable      = r_enable;
  assign plot        = r_enable;
  assign mouse_plot  = r_mouse_plot;
  assign reset_score = r_reset_score;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_grid_draw_ctrl.sv
// Directed bench for grid_draw_ctrl on a 2x3 board: frame walk, mouse interleave, idle cursor, async reset.
module tb_grid_draw_ctrl;
  localparam int ROWS = 2, COLS = 3, CELL_PIX = 16, MOUSE_PIX = 4;
  localparam int FRAME = 1 + ROWS * (1 + COLS * (1 + CELL_PIX));

  logic clk = 1'b0, reset_n = 1'b1, start = 1'b0, mouse_req = 1'b0;
  logic [4:0] register;
  logic [5:0] addr;
  logic mem_rd, ld_x, ld_y, ld_c, enable, plot, mouse_plot, reset_score, busy, done;

  int n_tests = 0, n_fail = 0;
  int n_clear, n_plot, n_mplot, n_mload, n_cells, clear_cyc, done_cyc, lat;
  int rows_q[$];
  int addrs_q[$];
  bit saw_done, found;

  always #5 clk = ~clk;

  grid_draw_ctrl #(.ROWS(ROWS), .COLS(COLS), .CELL_PIX(CELL_PIX), .MOUSE_PIX(MOUSE_PIX)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mouse_req(mouse_req),
    .register(register), .mem_rd(mem_rd), .addr(addr), .ld_x(ld_x), .ld_y(ld_y),
    .ld_c(ld_c), .enable(enable), .plot(plot), .mouse_plot(mouse_plot),
    .reset_score(reset_score), .busy(busy), .done(done)
  );

  function automatic logic [9:0] outs();
    return {mem_rd, ld_x, ld_y, ld_c, enable, plot, mouse_plot, reset_score, busy, done};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Runs one started frame, pulsing mouse_req at plots 3,6,9.. of the second cell (n_pulses of them).
  task automatic run_frame(input int n_pulses, input int start_at, input int max_cyc);
    int p, req_cyc;
    n_clear = 0; n_plot = 0; n_mplot = 0; n_mload = 0; n_cells = 0;
    clear_cyc = -1; done_cyc = -1; lat = -1; saw_done = 0; p = 0; req_cyc = -1;
    rows_q.delete(); addrs_q.delete();
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < max_cyc && !saw_done; i++) begin
      @(negedge clk);
      start = (i == start_at);
      mouse_req = 1'b0;
      if (!reset_score) begin n_clear++; if (clear_cyc < 0) clear_cyc = i; end
      if (mem_rd) rows_q.push_back(int'(register));
      if (ld_x && ld_c) begin n_cells++; addrs_q.push_back(int'(addr)); p = 0; end
      if (ld_x && !ld_c) n_mload++;
      if (plot) n_plot++;
      if (mouse_plot) n_mplot++;
      if (plot && mouse_plot && lat < 0 && req_cyc >= 0) lat = i - req_cyc;
      if (plot && !mouse_plot) begin
        p++;
        if (n_cells == 2 && p % 3 == 0 && p / 3 <= n_pulses) begin
          mouse_req = 1'b1;
          if (req_cyc < 0) req_cyc = i;
        end
      end
      if (done) begin
        saw_done = 1;
        done_cyc = i;
        check("done_cycle_busy_low", 32'(busy), 0);
      end
    end
    start = 1'b0;
    mouse_req = 1'b0;
    check("frame_done_seen", 32'(saw_done), 1);
    @(negedge clk);
`ifdef GRID_AUTO_FRAME_EN
    check("auto_restart_clear", {30'd0, reset_score, busy}, 32'b01);
`else
    check("idle_after_done", {29'd0, reset_score, busy, done}, 32'b100);
`endif
  endtask

  task automatic check_frame(input string t, input int n_draws);
    check({t, "_clear_cycles"}, n_clear, 1);
    check({t, "_fetch_count"}, rows_q.size(), 2 + n_draws);
    check({t, "_fetch_first_row"}, rows_q[0], 0);
    check({t, "_fetch_last_row"}, rows_q[rows_q.size() - 1], 1);
    if (n_draws > 0) check({t, "_refetch_row"}, rows_q[1], 0);
    check({t, "_cell_loads"}, addrs_q.size(), ROWS * COLS);
    for (int k = 0; k < ROWS * COLS; k++)
      check($sformatf("%s_addr%0d", t, k), addrs_q[k], k % COLS);
    check({t, "_plots"}, n_plot, ROWS * COLS * CELL_PIX + MOUSE_PIX * n_draws);
    check({t, "_mouse_cycles"}, n_mplot, (MOUSE_PIX + 1) * n_draws);
    check({t, "_mouse_loads"}, n_mload, n_draws);
    check({t, "_frame_len"}, done_cyc - clear_cyc, FRAME + (MOUSE_PIX + 2) * n_draws);
  endtask

  initial begin
    logic [4:0] exp_m;
    #1 reset_n = 1'b0;
    #1;
    check("reset_outputs", 32'(outs()), 32'b0000000100);
    check("reset_reg_addr", {21'd0, register, addr}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(0, -1, 300);
    check_frame("t1", 0);

    run_frame(1, -1, 300);
    check_frame("t2", 1);
    check("t2_mouse_latency_ok", 32'(lat >= 0 && lat <= CELL_PIX + 2), 1);

    run_frame(3, -1, 300);
    check_frame("t4", 1);

    run_frame(0, 20, 300);
    check_frame("t6", 0);

    // Idle cursor draw: M_LOAD, four M_DRAW plots, back to IDLE; {mouse_plot,plot,ld_x,busy,done}.
    @(negedge clk);
    mouse_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      mouse_req = 1'b0;
      exp_m = (k == 0) ? 5'b10100 : (k <= MOUSE_PIX) ? 5'b11000 : 5'b00000;
      check($sformatf("t3_idle_mouse_c%0d", k), {27'd0, mouse_plot, plot, ld_x, busy, done}, 32'(exp_m));
    end

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (register == 5'd1 && plot) found = 1;
    end
    check("t5_reached_row1_draw", 32'(found), 1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_reset_outputs", 32'(outs()), 32'b0000000100);
    check("t5_async_reset_reg_addr", {21'd0, register, addr}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_frame(0, -1, 300);
    check_frame("t5", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
